// File: rtl/mfilter_pkg.sv
// Shared constants, state encoding and tap-index to delay-line select map
// for the matched-filter tap sequencer.
package mfilter_pkg;

    localparam int NUM_TAPS = 6;
    localparam int SAMPLE_W = 8;
    localparam int SEL_W    = 3;
    localparam int IDX_W    = 3;
    localparam int FILL_W   = 3;
    localparam int DEC_W    = 8;
    localparam int WCNT_W   = 16;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_TAPS - 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_TAPS);
    localparam logic [SEL_W-1:0]  SEL_NEWEST = 3'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // The delay line's physical tap ordering is not monotonic in age.
    function automatic logic [SEL_W-1:0] tap_sel(input logic [IDX_W-1:0] idx);
        logic [SEL_W-1:0] sel;
        sel = SEL_NEWEST;
        case (idx)
            3'd0:    sel = 3'd3;
            3'd1:    sel = 3'd2;
            3'd2:    sel = 3'd5;
            3'd3:    sel = 3'd4;
            3'd4:    sel = 3'd1;
            3'd5:    sel = 3'd0;
            default: sel = SEL_NEWEST;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mfilter_tap_sequencer.sv
// Strobes RX samples into the 6-tap delay line and serialises a newest-first window burst every DECIM samples.
// Latency: tap 0 valid the cycle after the triggering accept; burst is 6 cycles minimum.
// Backpressure: in_ready low for the whole burst; tap words held while tap_valid && !tap_ready.
module mfilter_tap_sequencer
    import mfilter_pkg::*;
#(
    parameter logic [7:0] DECIM = 8'd1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [SAMPLE_W-1:0] i_in_sample,
    output logic                o_sr_strobe,
    output logic [SAMPLE_W-1:0] o_sr_sample,
    output logic                o_sr_clear,
    output logic [SEL_W-1:0]    o_sr_sel,
    input  logic [SAMPLE_W-1:0] i_sr_data,
    output logic                o_tap_valid,
    input  logic                i_tap_ready,
    output logic [SAMPLE_W-1:0] o_tap_data,
    output logic [IDX_W-1:0]    o_tap_index,
    output logic                o_tap_last,
    output logic [WCNT_W-1:0]   o_window_count
);

    // DECIM of zero behaves as one.
    localparam logic [DEC_W-1:0] DEC_LAST = (DECIM == 8'd0) ? 8'd0 : DECIM - 8'd1;

    state_t              r_state;
    logic [FILL_W-1:0]   r_fill;
    logic [DEC_W-1:0]    r_dec_cnt;
    logic [IDX_W-1:0]    r_tap_index;
    logic [SEL_W-1:0]    r_sel;
    logic                r_tap_valid;
    logic                r_clear;
    logic [WCNT_W-1:0]   r_window_count;

    logic                w_accept;
    logic [FILL_W-1:0]   w_fill_inc;
    logic                w_fill_full;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign o_in_ready  = (r_state == ST_IDLE) && !i_flush;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + 3'd1;
    assign w_fill_full = (w_fill_inc == FILL_FULL);
    assign w_idx_nxt   = r_tap_index + 3'd1;

    assign o_sr_strobe    = w_accept;
    assign o_sr_sample    = i_in_sample;
    assign o_sr_clear     = r_clear;
    assign o_sr_sel       = r_sel;
    assign o_tap_valid    = r_tap_valid;
    assign o_tap_data     = i_sr_data;
    assign o_tap_index    = r_tap_index;
    assign o_tap_last     = r_tap_valid && (r_tap_index == LAST_IDX);
    assign o_window_count = r_window_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_fill         <= '0;
            r_dec_cnt      <= '0;
            r_tap_index    <= '0;
            r_sel          <= SEL_NEWEST;
            r_tap_valid    <= 1'b0;
            r_clear        <= 1'b0;
            r_window_count <= '0;
        end else begin
            r_clear <= i_flush;
            if (i_flush) begin
                // Flush abandons any burst but keeps the completed-window tally.
                r_state     <= ST_IDLE;
                r_fill      <= '0;
                r_dec_cnt   <= '0;
                r_tap_index <= '0;
                r_sel       <= SEL_NEWEST;
                r_tap_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_fill <= w_fill_inc;
                            if (w_fill_full) begin
                                if (r_dec_cnt == DEC_LAST) begin
                                    r_dec_cnt   <= '0;
                                    r_state     <= ST_EMIT;
                                    r_tap_valid <= 1'b1;
                                    r_tap_index <= '0;
                                    r_sel       <= SEL_NEWEST;
                                end else begin
                                    r_dec_cnt <= r_dec_cnt + 8'd1;
                                end
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (i_tap_ready) begin
                            if (r_tap_index == LAST_IDX) begin
                                r_window_count <= r_window_count + 16'd1;
                                r_state        <= ST_IDLE;
                                r_tap_valid    <= 1'b0;
                                r_tap_index    <= '0;
                                r_sel          <= SEL_NEWEST;
                            end else begin
                                r_tap_index <= w_idx_nxt;
                                r_sel       <= tap_sel(w_idx_nxt);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
